// File: rtl/sipo_framer.sv
// sipo_framer: serial-in/parallel-out deserialiser with word framing, a held output word and a valid/ready handshake
module sipo_framer #(
    parameter int WIDTH     = 16,
    parameter bit MSB_FIRST = 0
) (
    input  logic                     clk,
    input  logic                     rnot,
    input  logic                     clear,
    input  logic                     enable,
    input  logic                     in,
    output logic [WIDTH-1:0]         out,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [WIDTH-1:0]         shift,
    output logic [$clog2(WIDTH)-1:0] bit_count,
    output logic                     overflow
);
    logic [WIDTH-1:0]         sr, sr_next;
    logic [$clog2(WIDTH)-1:0] cnt, cnt_next;
    logic                     done;

    assign shift     = sr;
    assign bit_count = cnt;

    // next shift value and word-completion detection for this edge
    always_comb begin
        sr_next  = MSB_FIRST ? {sr[WIDTH-2:0], in} : {in, sr[WIDTH-1:1]};
        done     = enable && (cnt == ($clog2(WIDTH))'(WIDTH - 1));
        cnt_next = done ? '0 : cnt + 1'b1;
    end

    // shift/count, load the holding register or flag a dropped word, and run the handshake
    always_ff @(posedge clk or negedge rnot) begin
        if (!rnot) begin
            sr        <= '0;
            cnt       <= '0;
            out       <= '0;
            out_valid <= 1'b0;
            overflow  <= 1'b0;
        end else if (clear) begin
            sr        <= '0;
            cnt       <= '0;
            out       <= '0;
            out_valid <= 1'b0;
            overflow  <= 1'b0;
        end else begin
            if (enable) begin
                sr  <= sr_next;
                cnt <= cnt_next;
            end
            if (done && (!out_valid || out_ready)) begin
                out       <= sr_next;
                out_valid <= 1'b1;
            end else if (done) begin
                overflow <= 1'b1;
            end else if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_sipo_framer.sv
// tb_sipo_framer: directed tests for sipo_framer in LSB-first, MSB-first and 8-bit configurations
module tb_sipo_framer;
    logic clk = 0;
    logic rnot = 1;
    logic clear = 0;
    logic enable = 0;
    logic in = 0;
    logic out_ready = 1;

    logic [15:0] a_out, a_shift, b_out, b_shift;
    logic [3:0]  a_cnt, b_cnt;
    logic        a_valid, a_ovf, b_valid, b_ovf;
    logic [7:0]  c_out, c_shift;
    logic [2:0]  c_cnt;
    logic        c_valid, c_ovf;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    sipo_framer #(.WIDTH(16), .MSB_FIRST(0)) u_a (
        .clk(clk), .rnot(rnot), .clear(clear), .enable(enable), .in(in),
        .out(a_out), .out_valid(a_valid), .out_ready(out_ready),
        .shift(a_shift), .bit_count(a_cnt), .overflow(a_ovf)
    );
    sipo_framer #(.WIDTH(16), .MSB_FIRST(1)) u_b (
        .clk(clk), .rnot(rnot), .clear(clear), .enable(enable), .in(in),
        .out(b_out), .out_valid(b_valid), .out_ready(out_ready),
        .shift(b_shift), .bit_count(b_cnt), .overflow(b_ovf)
    );
    sipo_framer #(.WIDTH(8), .MSB_FIRST(0)) u_c (
        .clk(clk), .rnot(rnot), .clear(clear), .enable(enable), .in(in),
        .out(c_out), .out_valid(c_valid), .out_ready(out_ready),
        .shift(c_shift), .bit_count(c_cnt), .overflow(c_ovf)
    );

    // drive bits lo..hi of w LSB-first on falling edges, then drop enable
    task automatic send_bits(input logic [15:0] w, input int lo, input int hi);
        for (int i = lo; i <= hi; i++) begin
            @(negedge clk);
            enable = 1;
            in = w[i];
        end
        @(negedge clk);
        enable = 0;
    endtask

    task automatic pulse_clear();
        clear = 1;
        @(negedge clk);
        clear = 0;
    endtask

    task automatic test_reset();
        #2 rnot = 0;
        #1;
        tests++; if (a_out !== 16'h0) begin fails++; $display("FAIL reset_out got %h exp 0000", a_out); end
        tests++; if (a_valid !== 1'b0) begin fails++; $display("FAIL reset_valid got %b exp 0", a_valid); end
        tests++; if (a_shift !== 16'h0) begin fails++; $display("FAIL reset_shift got %h exp 0000", a_shift); end
        tests++; if (a_cnt !== 4'd0) begin fails++; $display("FAIL reset_count got %0d exp 0", a_cnt); end
        tests++; if (a_ovf !== 1'b0) begin fails++; $display("FAIL reset_ovf got %b exp 0", a_ovf); end
        @(negedge clk);
        rnot = 1;
    endtask

    task automatic test_basic();
        out_ready = 1;
        send_bits(16'h8889, 0, 15);
        tests++; if (a_out !== 16'h8889) begin fails++; $display("FAIL lsb_word got %h exp 8889", a_out); end
        tests++; if (a_valid !== 1'b1) begin fails++; $display("FAIL lsb_valid got %b exp 1", a_valid); end
        tests++; if (a_cnt !== 4'd0) begin fails++; $display("FAIL lsb_count_wrap got %0d exp 0", a_cnt); end
        tests++; if (a_ovf !== 1'b0) begin fails++; $display("FAIL lsb_ovf got %b exp 0", a_ovf); end
        tests++; if (b_out !== 16'h9111) begin fails++; $display("FAIL msb_word got %h exp 9111", b_out); end
        tests++; if (b_valid !== 1'b1) begin fails++; $display("FAIL msb_valid got %b exp 1", b_valid); end
        @(negedge clk);
        tests++; if (a_valid !== 1'b0) begin fails++; $display("FAIL lsb_valid_one_cycle got %b exp 0", a_valid); end
    endtask

    task automatic test_overflow();
        out_ready = 0;
        send_bits(16'h8889, 0, 15);
        send_bits(16'h1234, 0, 15);
        tests++; if (a_out !== 16'h8889) begin fails++; $display("FAIL ovf_out_held got %h exp 8889", a_out); end
        tests++; if (a_valid !== 1'b1) begin fails++; $display("FAIL ovf_valid got %b exp 1", a_valid); end
        tests++; if (a_ovf !== 1'b1) begin fails++; $display("FAIL ovf_set got %b exp 1", a_ovf); end
        out_ready = 1;
        @(negedge clk);
        out_ready = 0;
        tests++; if (a_valid !== 1'b0) begin fails++; $display("FAIL ovf_consume got %b exp 0", a_valid); end
        tests++; if (a_ovf !== 1'b1) begin fails++; $display("FAIL ovf_sticky got %b exp 1", a_ovf); end
        tests++; if (a_out !== 16'h8889) begin fails++; $display("FAIL ovf_out_after got %h exp 8889", a_out); end
    endtask

    task automatic test_gap_and_clear();
        pulse_clear();
        out_ready = 1;
        send_bits(16'h3C5A, 0, 6);
        repeat (4) @(negedge clk);
        tests++; if (a_cnt !== 4'd7) begin fails++; $display("FAIL gap_count got %0d exp 7", a_cnt); end
        send_bits(16'h3C5A, 7, 15);
        tests++; if (a_out !== 16'h3C5A) begin fails++; $display("FAIL gap_word got %h exp 3c5a", a_out); end
        tests++; if (a_valid !== 1'b1) begin fails++; $display("FAIL gap_valid got %b exp 1", a_valid); end
        out_ready = 0;
        send_bits(16'h0000, 0, 15);
        send_bits(16'hFFFF, 0, 4);
        tests++; if (a_shift !== 16'hF800) begin fails++; $display("FAIL partial_shift got %h exp f800", a_shift); end
        tests++; if (a_ovf !== 1'b1) begin fails++; $display("FAIL pre_clear_ovf got %b exp 1", a_ovf); end
        pulse_clear();
        tests++; if (a_shift !== 16'h0) begin fails++; $display("FAIL clear_shift got %h exp 0000", a_shift); end
        tests++; if (a_cnt !== 4'd0) begin fails++; $display("FAIL clear_count got %0d exp 0", a_cnt); end
        tests++; if (a_valid !== 1'b0) begin fails++; $display("FAIL clear_valid got %b exp 0", a_valid); end
        tests++; if (a_ovf !== 1'b0) begin fails++; $display("FAIL clear_ovf got %b exp 0", a_ovf); end
        tests++; if (a_out !== 16'h0) begin fails++; $display("FAIL clear_out got %h exp 0000", a_out); end
    endtask

    task automatic test_async_reset();
        out_ready = 1;
        send_bits(16'hA5A5, 0, 8);
        tests++; if (a_cnt !== 4'd9) begin fails++; $display("FAIL pre_reset_count got %0d exp 9", a_cnt); end
        @(negedge clk);
        enable = 1;
        in = 1'b0;
        #2 rnot = 0;
        #1;
        tests++; if (a_shift !== 16'h0) begin fails++; $display("FAIL areset_shift got %h exp 0000", a_shift); end
        tests++; if (a_cnt !== 4'd0) begin fails++; $display("FAIL areset_count got %0d exp 0", a_cnt); end
        tests++; if (a_valid !== 1'b0) begin fails++; $display("FAIL areset_valid got %b exp 0", a_valid); end
        @(negedge clk);
        enable = 0;
        rnot = 1;
        send_bits(16'hA5A5, 0, 15);
        tests++; if (a_out !== 16'hA5A5) begin fails++; $display("FAIL post_reset_word got %h exp a5a5", a_out); end
        tests++; if (a_valid !== 1'b1) begin fails++; $display("FAIL post_reset_valid got %b exp 1", a_valid); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] stream;
        logic        exp_v;
        stream = 32'hFE01A73C;
        out_ready = 1;
        pulse_clear();
        for (int k = 0; k <= 32; k++) begin
            @(negedge clk);
            exp_v = (k > 0) && (k % 8 == 0);
            tests++; if (c_valid !== exp_v) begin fails++; $display("FAIL stream_valid k=%0d got %b exp %b", k, c_valid, exp_v); end
            if (exp_v) begin
                tests++; if (c_out !== stream[k-1 -: 8]) begin fails++; $display("FAIL stream_word k=%0d got %h exp %h", k, c_out, stream[k-1 -: 8]); end
            end
            if (k < 32) begin
                enable = 1;
                in = stream[k];
            end else begin
                enable = 0;
            end
        end
        tests++; if (c_ovf !== 1'b0) begin fails++; $display("FAIL stream_ovf got %b exp 0", c_ovf); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_overflow();
        test_gap_and_clear();
        test_async_reset();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
